// File: rtl/madd_eval_pkg.sv
// Shared constants, FSM state type and exact multiply-add reference for the
// approximate madd evaluation harnesses.
package madd_eval_pkg;

  localparam int W_OP  = 6;
  localparam int W_RES = 2 * W_OP;
  localparam int W_VEC = 3 * W_OP;
  localparam int N_VEC = 1 << W_VEC;

  // Field index of each operand inside the driven vector, in units of W_OP.
  localparam int A_FIELD = 0;
  localparam int B_FIELD = 1;
  localparam int C_FIELD = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int unsigned madd_exact(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
    return a * b + c;
  endfunction

endpackage

// File: rtl/madd_err_sweep_accum.sv
// S2/S3 of the error pipeline: absolute difference, then count/sum/max update.
// Two-cycle latency from the S1 pair to the metrics; no backpressure.
module err_accum #(
  parameter int W_RES = 12,
  parameter int W_TAG = 18,
  parameter int W_CNT = 19,
  parameter int W_SUM = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s1_vld,
  input  logic [W_RES-1:0] s1_approx,
  input  logic [W_RES-1:0] s1_exact,
  input  logic [W_TAG-1:0] s1_tag,
  output logic [W_CNT-1:0] err_count,
  output logic [W_SUM-1:0] err_sum,
  output logic [W_RES-1:0] err_max,
  output logic [W_TAG-1:0] err_max_vec
);

  logic signed [W_RES:0] diff_s;
  logic                  s2_vld;
  logic [W_RES-1:0]      s2_diff;
  logic [W_TAG-1:0]      s2_tag;

  assign diff_s = $signed({1'b0, s1_approx}) - $signed({1'b0, s1_exact});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_diff <= '0;
      s2_tag  <= '0;
    end else begin
      s2_vld  <= s1_vld & ~clr;
      s2_diff <= W_RES'(diff_s[W_RES] ? -diff_s : diff_s);
      s2_tag  <= s1_tag;
    end
  end

  // Strictly-greater compare keeps the first vector that reached the max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count   <= '0;
      err_sum     <= '0;
      err_max     <= '0;
      err_max_vec <= '0;
    end else if (clr) begin
      err_count   <= '0;
      err_sum     <= '0;
      err_max     <= '0;
      err_max_vec <= '0;
    end else if (s2_vld) begin
      if (s2_diff != '0) err_count <= err_count + W_CNT'(1);
      err_sum <= err_sum + W_SUM'(s2_diff);
      if (s2_diff > err_max) begin
        err_max     <= s2_diff;
        err_max_vec <= s2_tag;
      end
    end
  end

endmodule

// File: rtl/madd_err_sweep.sv
// Exhaustive error sweep of an approximate a*b+c netlist with start/done handshake.
// Metrics final DUT_LAT+2 cycles after the last vector is driven; no backpressure.
module madd_err_sweep #(
  parameter int W_OP    = 6,
  parameter int W_RES   = 12,
  parameter int DUT_LAT = 0,
  parameter int W_SUM   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [3*W_OP-1:0] dut_in,
  input  logic [W_RES-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic [3*W_OP:0]   err_count,
  output logic [W_SUM-1:0]  err_sum,
  output logic [W_RES-1:0]  err_max,
  output logic [3*W_OP-1:0] err_max_vec
);
  import madd_eval_pkg::*;

  localparam int            VW       = 3 * W_OP;
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam int            DW       = $clog2(DUT_LAT + 2);
  localparam logic [DW-1:0] DRN_LAST = DW'(DUT_LAT + 1);

  state_t           state;
  logic [VW-1:0]    vec;
  logic [DW-1:0]    dcnt;
  logic             clr;
  logic [W_OP-1:0]  op_a, op_b, op_c;
  logic [W_RES-1:0] exact_now;
  logic [W_RES-1:0] exact_d;
  logic [VW-1:0]    tag_d;
  logic             vld_d;
  logic             s1_vld;
  logic [W_RES-1:0] s1_approx, s1_exact;
  logic [VW-1:0]    s1_tag;

  assign clr    = start & (state == ST_IDLE || state == ST_DONE);
  assign busy   = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign done   = (state == ST_DONE);
  assign dut_in = vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      vec   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_SWEEP;
            vec   <= '0;
          end
        end
        ST_SWEEP: begin
          if (vec == VEC_LAST) begin
            state <= ST_DRAIN;
            dcnt  <= '0;
          end else begin
            vec <= vec + VW'(1);
          end
        end
        ST_DRAIN: begin
          if (dcnt == DRN_LAST) state <= ST_DONE;
          else                  dcnt  <= dcnt + DW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign op_a      = vec[A_FIELD*W_OP +: W_OP];
  assign op_b      = vec[B_FIELD*W_OP +: W_OP];
  assign op_c      = vec[C_FIELD*W_OP +: W_OP];
  assign exact_now = W_RES'(madd_exact(32'(op_a), 32'(op_b), 32'(op_c)));

  // Exact result, tag and valid ride a delay line matching the netlist depth.
  if (DUT_LAT == 0) begin : g_nodly
    assign exact_d = exact_now;
    assign tag_d   = vec;
    assign vld_d   = (state == ST_SWEEP);
  end else begin : g_dly
    logic [W_RES-1:0]   ex_sr  [DUT_LAT];
    logic [VW-1:0]      tag_sr [DUT_LAT];
    logic [DUT_LAT-1:0] vld_sr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DUT_LAT; i++) begin
          ex_sr[i]  <= '0;
          tag_sr[i] <= '0;
        end
        vld_sr <= '0;
      end else begin
        ex_sr[0]  <= exact_now;
        tag_sr[0] <= vec;
        vld_sr[0] <= (state == ST_SWEEP);
        for (int i = 1; i < DUT_LAT; i++) begin
          ex_sr[i]  <= ex_sr[i-1];
          tag_sr[i] <= tag_sr[i-1];
          vld_sr[i] <= vld_sr[i-1];
        end
      end
    end

    assign exact_d = ex_sr[DUT_LAT-1];
    assign tag_d   = tag_sr[DUT_LAT-1];
    assign vld_d   = vld_sr[DUT_LAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
      s1_tag    <= '0;
    end else begin
      s1_vld    <= vld_d;
      s1_approx <= dut_out;
      s1_exact  <= exact_d;
      s1_tag    <= tag_d;
    end
  end

  err_accum #(
    .W_RES (W_RES),
    .W_TAG (VW),
    .W_CNT (VW + 1),
    .W_SUM (W_SUM)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .s1_vld      (s1_vld),
    .s1_approx   (s1_approx),
    .s1_exact    (s1_exact),
    .s1_tag      (s1_tag),
    .err_count   (err_count),
    .err_sum     (err_sum),
    .err_max     (err_max),
    .err_max_vec (err_max_vec)
  );

endmodule

// File: tb/tb_madd_err_sweep.sv
// Bench for madd_err_sweep on a 3-bit-operand build (512 vectors), latency 0 and 2.
module tb_madd_err_sweep;

  localparam int NV = 512;

  logic       clk, rst;
  logic       start0, start2;
  logic [8:0] din0, din2, vec0, vec2;
  logic [5:0] dout0, dout2, max0, max2;
  logic       busy0, busy2, done0, done2;
  logic [9:0] cnt0, cnt2;
  logic [31:0] sum0, sum2;
  logic [5:0] r1, r2;

  int   mode;
  int   noise [NV];
  logic sel;
  int   tests, fails;

  logic       busy_v, done_v;
  logic [8:0] din_v, vec_v;
  logic [9:0] cnt_v;
  logic [31:0] sum_v;
  logic [5:0] max_v;

  typedef struct {
    string name;
    int    mode;
    int    lat;
    int    ecnt;
    int    esum;
    int    emax;
    int    evec;
    int    ecyc;
  } row_t;
  row_t tbl [8];

  madd_err_sweep #(.W_OP(3), .W_RES(6), .DUT_LAT(0), .W_SUM(32)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(din0), .dut_out(dout0),
    .busy(busy0), .done(done0), .err_count(cnt0), .err_sum(sum0),
    .err_max(max0), .err_max_vec(vec0));

  madd_err_sweep #(.W_OP(3), .W_RES(6), .DUT_LAT(2), .W_SUM(32)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_in(din2), .dut_out(dout2),
    .busy(busy2), .done(done2), .err_count(cnt2), .err_sum(sum2),
    .err_max(max2), .err_max_vec(vec2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in netlists: mode 0 exact, 1 stuck-at-0, 2 exact^1, 3 exact^noise.
  function automatic int approx_of(input int m, input int v, input int nz);
    int ex;
    ex = (v & 7) * ((v >> 3) & 7) + ((v >> 6) & 7);
    case (m)
      0:       return ex;
      1:       return 0;
      2:       return ex ^ 1;
      default: return ex ^ nz;
    endcase
  endfunction

  assign dout0 = 6'(approx_of(mode, int'(din0), noise[din0]));

  always @(posedge clk) begin
    r1 <= 6'(approx_of(mode, int'(din2), noise[din2]));
    r2 <= r1;
  end
  assign dout2 = r2;

  always_comb begin
    busy_v = sel ? busy2 : busy0;
    done_v = sel ? done2 : done0;
    din_v  = sel ? din2  : din0;
    vec_v  = sel ? vec2  : vec0;
    cnt_v  = sel ? cnt2  : cnt0;
    sum_v  = sel ? sum2  : sum0;
    max_v  = sel ? max2  : max0;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input int m, output int cnt, output int sum,
                       output int mx, output int mv);
    cnt = 0; sum = 0; mx = 0; mv = 0;
    for (int v = 0; v < NV; v++) begin
      int ex, ap, d;
      ex = (v & 7) * ((v >> 3) & 7) + ((v >> 6) & 7);
      ap = approx_of(m, v, noise[v]) & 63;
      d  = (ap > ex) ? ap - ex : ex - ap;
      if (d != 0) cnt++;
      sum += d;
      if (d > mx) begin
        mx = d;
        mv = v;
      end
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start2 = v;
    else     start0 = v;
  endtask

  // Pulses start, optionally re-pulses it after cycles inj_a / inj_b, and
  // returns the number of edges from the start edge to the rise of done.
  task automatic run_sweep(input string nm, input int inj_a, input int inj_b,
                           output int cyc);
    int n;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    chk({nm, " busy_at_start"}, busy_v, 1);
    chk({nm, " done_at_start"}, done_v, 0);
    chk({nm, " dut_in_at_start"}, din_v, 0);
    chk({nm, " count_cleared"}, cnt_v, 0);
    n = 0;
    while (!done_v && n < 2000) begin
      if (n == inj_a || n == inj_b) set_start(1'b1);
      @(posedge clk);
      #1;
      n++;
      set_start(1'b0);
    end
    cyc = n;
  endtask

  task automatic check_res(input string nm, input int cyc, input int ecyc,
                           input int ecnt, input int esum, input int emax,
                           input int evec);
    chk({nm, " done_cycles"}, cyc, ecyc);
    chk({nm, " busy_low"}, busy_v, 0);
    chk({nm, " dut_in_hold"}, din_v, NV - 1);
    chk({nm, " err_count"}, cnt_v, ecnt);
    chk({nm, " err_sum"}, sum_v, esum);
    chk({nm, " err_max"}, max_v, emax);
    chk({nm, " err_max_vec"}, vec_v, evec);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " done_held"}, done_v, 1);
    chk({nm, " sum_held"}, sum_v, esum);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " busy"}, busy_v, 0);
    chk({nm, " done"}, done_v, 0);
    chk({nm, " dut_in"}, din_v, 0);
    chk({nm, " err_count"}, cnt_v, 0);
    chk({nm, " err_sum"}, sum_v, 0);
    chk({nm, " err_max"}, max_v, 0);
    chk({nm, " err_max_vec"}, vec_v, 0);
  endtask

  initial begin
    int cyc, c, s, m, v;
    tests = 0; fails = 0;
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; mode = 0; sel = 1'b0;
    for (int i = 0; i < NV; i++)
      noise[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 63)) : 0;

    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; check_zero("reset_l0");
    sel = 1'b1; #1; check_zero("reset_l2");
    @(negedge clk);
    rst = 1'b0;

    // stuck-at-0 over 3-bit operands: 15 zero results, sum 8064, max 7*7+7
    tbl[0] = '{"exact_l0",  0, 0, 0,   0,    0,  0,   514};
    tbl[1] = '{"stuck0_l0", 1, 0, 497, 8064, 56, 511, 514};
    tbl[2] = '{"xor1_l0",   2, 0, 512, 512,  1,  0,   514};
    tbl[3] = '{"exact_l2",  0, 2, 0,   0,    0,  0,   516};
    tbl[4] = '{"stuck0_l2", 1, 2, 497, 8064, 56, 511, 516};
    tbl[5] = '{"xor1_l2",   2, 2, 512, 512,  1,  0,   516};
    model(3, c, s, m, v);
    tbl[6] = '{"rand_l0",   3, 0, c, s, m, v, 514};
    tbl[7] = '{"rand_l2",   3, 2, c, s, m, v, 516};

    for (int r = 0; r < 8; r++) begin
      mode = tbl[r].mode;
      sel  = (tbl[r].lat == 2);
      run_sweep(tbl[r].name, -1, -1, cyc);
      check_res(tbl[r].name, cyc, tbl[r].ecyc, tbl[r].ecnt, tbl[r].esum,
                tbl[r].emax, tbl[r].evec);
    end

    // Extra starts mid-sweep and during drain must be ignored.
    mode = 1; sel = 1'b0;
    run_sweep("inject", 100, NV, cyc);
    check_res("inject", cyc, 514, 497, 8064, 56, 511);
    run_sweep("rerun", -1, -1, cyc);
    check_res("rerun", cyc, 514, 497, 8064, 56, 511);

    // Asynchronous reset partway through a sweep.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("midrst busy_before", busy_v, 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_sweep("after_rst", -1, -1, cyc);
    check_res("after_rst", cyc, 514, 497, 8064, 56, 511);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
